// File: rtl/avalon_burst_host.sv
// Purpose   : Avalon-MM burst host; splits one read/write command into bursts of at most 2**(BURSTCOUNT_W-1) words.
// Latency   : read data 1 cycle after avm_readdatavalid; done 1 cycle after the last write beat / with the last rd_valid.
// Backpress : wr stream stalled by avm_waitrequest; rd stream has no backpressure; one command at a time (cmd_ready only in IDLE).
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_write, cmd_addr (byte, word-aligned), cmd_len (words, 0 = no-op)
//   wr_data/wr_valid/wr_ready  write data stream into the host
//   rd_data/rd_valid           read data stream out of the host (registered, 1-cycle pulses)
//   busy, done                 status: busy while not IDLE, done pulses once per command
//   avm_*                      Avalon-MM host side towards the agent
module avalon_burst_host #(
   parameter int ADDR_W       = 32,
   parameter int BURSTCOUNT_W = 4,
   parameter int LEN_W        = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_W-1:0]       cmd_addr,
   input  logic [LEN_W-1:0]        cmd_len,
   input  logic [31:0]             wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [31:0]             rd_data,
   output logic                    rd_valid,
   output logic                    busy,
   output logic                    done,
   output logic [ADDR_W-1:0]       avm_address,
   output logic [BURSTCOUNT_W-1:0] avm_burstcount,
   output logic                    avm_read,
   output logic                    avm_write,
   output logic [31:0]             avm_writedata,
   output logic [3:0]              avm_byteenable,
   input  logic [31:0]             avm_readdata,
   input  logic                    avm_readdatavalid,
   input  logic                    avm_waitrequest
);

   localparam int MAX_BURST = 2**(BURSTCOUNT_W-1);
   localparam logic [LEN_W-1:0] MAX_BURST_L = LEN_W'(MAX_BURST);

   typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_DATA, DONE} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_W-1:0]       addr;
   logic [LEN_W-1:0]        remaining;
   logic [BURSTCOUNT_W-1:0] beat_cnt;
   logic [BURSTCOUNT_W-1:0] burst_n;
   logic                    avm_read_q;
   logic                    rd_valid_q;
   logic [31:0]             rd_data_q;
   logic [3:0]              byteenable_q;

   logic                    cmd_acc;
   logic                    beat;
   logic                    last_beat;
   logic [LEN_W-1:0]        rem_after;

   // Words in the next burst: min(n, MAX_BURST); always fits in BURSTCOUNT_W bits.
   function automatic logic [BURSTCOUNT_W-1:0] clip_burst(input logic [LEN_W-1:0] n);
      clip_burst = (n > MAX_BURST_L) ? MAX_BURST_L[BURSTCOUNT_W-1:0] : n[BURSTCOUNT_W-1:0];
   endfunction

   always_comb begin
      state_nxt     = state;
      cmd_ready     = (state == IDLE) && !reset;
      busy          = (state != IDLE);
      done          = (state == DONE);
      avm_write     = (state == WR_BURST) && wr_valid;
      wr_ready      = (state == WR_BURST) && !avm_waitrequest;
      avm_writedata = (state == WR_BURST) ? wr_data : 32'h0;
      cmd_acc       = cmd_valid && cmd_ready;
      // A beat is a write handshake or a returned read word; readdatavalid outside RD_DATA is ignored.
      beat          = ((state == WR_BURST) && wr_valid && !avm_waitrequest) ||
                      ((state == RD_DATA) && avm_readdatavalid);
      last_beat     = beat && (beat_cnt == burst_n - BURSTCOUNT_W'(1));
      rem_after     = remaining - LEN_W'(burst_n);

      case (state)
         IDLE: begin
            if (cmd_acc) begin
               if (cmd_len == '0)  state_nxt = DONE;
               else if (cmd_write) state_nxt = WR_BURST;
               else                state_nxt = RD_CMD;
            end
         end
         // Back-to-back write bursts stay in WR_BURST with no idle cycle.
         WR_BURST: if (last_beat && rem_after == '0) state_nxt = DONE;
         RD_CMD:   if (!avm_waitrequest) state_nxt = RD_DATA;
         RD_DATA:  if (last_beat) state_nxt = (rem_after == '0) ? DONE : RD_CMD;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         addr         <= '0;
         remaining    <= '0;
         beat_cnt     <= '0;
         burst_n      <= '0;
         avm_read_q   <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= 32'h0;
         byteenable_q <= 4'h0;
      end else begin
         state        <= state_nxt;
         byteenable_q <= 4'hF;
         // avm_read is a register that mirrors "next state is RD_CMD", so it drops on the issue cycle.
         avm_read_q   <= (state_nxt == RD_CMD);
         rd_valid_q   <= (state == RD_DATA) && avm_readdatavalid;
         if ((state == RD_DATA) && avm_readdatavalid) rd_data_q <= avm_readdata;

         if (cmd_acc) begin
            addr      <= cmd_addr & ~ADDR_W'(3);
            remaining <= cmd_len;
            burst_n   <= clip_burst(cmd_len);
            beat_cnt  <= '0;
         end else if (last_beat) begin
            addr      <= addr + (ADDR_W'(burst_n) << 2);
            remaining <= rem_after;
            burst_n   <= clip_burst(rem_after);
            beat_cnt  <= '0;
         end else if (beat) begin
            beat_cnt  <= beat_cnt + BURSTCOUNT_W'(1);
         end
      end
   end

   assign avm_address    = addr;
   assign avm_burstcount = burst_n;
   assign avm_read       = avm_read_q;
   assign rd_valid       = rd_valid_q;
   assign rd_data        = rd_data_q;
   assign avm_byteenable = byteenable_q;

endmodule

// File: tb/tb_avalon_burst_host.sv
// Purpose   : directed bench for avalon_burst_host with a behavioural 256-word burst BRAM agent.
// Latency   : agent returns read data starting the cycle after a read command is accepted.
// Backpress : optional random waitrequest, random readdatavalid gaps and random wr_valid gaps.
module tb_avalon_burst_host;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [15:0] cmd_len = '0;
   logic [31:0] wr_data;
   logic        wr_valid = 1'b0, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, busy, done;
   logic [31:0] avm_address;
   logic [3:0]  avm_burstcount;
   logic        avm_read, avm_write;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata = '0;
   logic        avm_readdatavalid = 1'b0, avm_waitrequest = 1'b0;

   always #5 clk = ~clk;

   avalon_burst_host #(.ADDR_W(32), .BURSTCOUNT_W(4), .LEN_W(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
      .avm_address(avm_address), .avm_burstcount(avm_burstcount),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
   );

   int tests_run = 0, tests_failed = 0;
   int cyc = 0;
   logic stall_mode = 1'b0, gap_mode = 1'b0;

   logic [31:0] mem [0:255];
   logic [31:0] exp_mem [0:255];

   function automatic logic [31:0] data_fn(input int s);
      return {8'hA5, 24'(s * 7 + 1)};
   endfunction

   // Write source: word n of the stream carries data_fn(n).
   int wr_seq = 0;
   always_comb wr_data = data_fn(wr_seq);

   // Agent model state and logs
   int wr_left = 0, wr_idx = 0, rd_left = 0, rd_idx = 0;
   int wr_bursts = 0, rd_bursts = 0, wr_beats = 0, stab_err = 0, ovl_err = 0;
   int last_wr_beat_cyc = 0;
   logic [31:0] wr_base = '0, rd_base = '0;
   logic [3:0]  wr_bc = '0;
   int wr_addr_log [0:63], wr_bc_log [0:63], rd_addr_log [0:63], rd_bc_log [0:63];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (reset) begin
         wr_left <= 0; rd_left <= 0;
         avm_readdatavalid <= 1'b0; avm_waitrequest <= 1'b0;
      end else begin
         avm_waitrequest   <= stall_mode ? 1'($urandom_range(0, 1)) : 1'b0;
         avm_readdatavalid <= 1'b0;
         if (wr_left != 0 && (avm_address !== wr_base || avm_burstcount !== wr_bc))
            stab_err <= stab_err + 1;
         if (avm_write && !avm_waitrequest) begin
            if (wr_left == 0) begin
               wr_base <= avm_address; wr_bc <= avm_burstcount;
               wr_left <= int'(avm_burstcount) - 1; wr_idx <= 1;
               wr_addr_log[wr_bursts] <= int'(avm_address);
               wr_bc_log[wr_bursts]   <= int'(avm_burstcount);
               wr_bursts <= wr_bursts + 1;
               mem[avm_address[9:2]] <= avm_writedata;
            end else begin
               mem[8'(int'(wr_base[9:2]) + wr_idx)] <= avm_writedata;
               wr_left <= wr_left - 1; wr_idx <= wr_idx + 1;
            end
            wr_beats <= wr_beats + 1;
            last_wr_beat_cyc <= cyc;
         end
         if (avm_read && !avm_waitrequest) begin
            if (rd_left != 0) ovl_err <= ovl_err + 1;
            rd_base <= avm_address; rd_left <= int'(avm_burstcount); rd_idx <= 0;
            rd_addr_log[rd_bursts] <= int'(avm_address);
            rd_bc_log[rd_bursts]   <= int'(avm_burstcount);
            rd_bursts <= rd_bursts + 1;
         end else if (rd_left != 0 && (!stall_mode || $urandom_range(0, 1) == 1)) begin
            avm_readdatavalid <= 1'b1;
            avm_readdata <= mem[8'(int'(rd_base[9:2]) + rd_idx)];
            rd_left <= rd_left - 1; rd_idx <= rd_idx + 1;
         end
      end
   end

   // Host-side stream monitors
   int rd_cnt = 0, hs_cnt = 0, done_cnt = 0, act_cnt = 0, last_rdv_cyc = 0;
   logic hs_last = 1'b0;
   logic [31:0] rd_q [$];

   always @(posedge clk) begin
      if (rd_valid) begin rd_q.push_back(rd_data); rd_cnt <= rd_cnt + 1; last_rdv_cyc <= cyc; end
      hs_last <= wr_valid && wr_ready;
      if (wr_valid && wr_ready) begin hs_cnt <= hs_cnt + 1; wr_seq <= wr_seq + 1; end
      if (done) done_cnt <= done_cnt + 1;
      if (avm_read || avm_write) act_cnt <= act_cnt + 1;
   end

   // wr_valid only changes when idle or right after a handshake, so valid is never withdrawn.
   always @(negedge clk)
      if (!wr_valid || hs_last) wr_valid = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic issue_cmd(input logic w, input logic [31:0] a, input int len, input bit hold, output int acc_cyc);
      int n = 0;
      cmd_write = w; cmd_addr = a; cmd_len = 16'(len); cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin tick(); n++; end
      if (n >= 200) begin
         tests_run++; tests_failed++;
         $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
      end
      acc_cyc = cyc;
      tick();
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int dcyc);
      int n = 0;
      while (!done && n < budget) begin tick(); n++; end
      if (n >= budget) begin
         tests_run++; tests_failed++;
         $display("FAIL done_timeout: done not seen within %0d cycles", budget);
      end
      dcyc = cyc;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      tests_run++;
      if ({cmd_ready, busy, done, avm_read, avm_write, wr_ready, rd_valid, avm_byteenable,
           avm_burstcount, avm_address, rd_data, avm_writedata} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: cmd_ready=%b busy=%b be=%h addr=%h bc=%0d, required all 0",
                  cmd_ready, busy, avm_byteenable, avm_address, avm_burstcount);
      end
      reset = 1'b0;
      tick();
      tests_run++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin tests_failed++;
         $display("FAIL reset_release_ready: cmd_ready=%b busy=%b, required 1/0", cmd_ready, busy); end
      tests_run++;
      if (avm_byteenable !== 4'hF) begin tests_failed++;
         $display("FAIL reset_release_be: got %h required f", avm_byteenable); end
   endtask

   task automatic test_single_write();
      int s0 = wr_seq, b0 = wr_bursts, w0 = wr_beats, d0 = done_cnt, acc, dc;
      issue_cmd(1'b1, 32'h10, 3, 1'b0, acc);
      wait_done(100, dc);
      for (int i = 0; i < 3; i++) exp_mem[4 + i] = data_fn(s0 + i);
      tests_run++;
      if (wr_bursts - b0 != 1 || wr_addr_log[b0] != 32'h10 || wr_bc_log[b0] != 3) begin tests_failed++;
         $display("FAIL t1_burst: bursts=%0d addr=%h bc=%0d required 1/10/3", wr_bursts - b0, wr_addr_log[b0], wr_bc_log[b0]); end
      tests_run++;
      if (wr_beats - w0 != 3) begin tests_failed++;
         $display("FAIL t1_beats: got %0d required 3", wr_beats - w0); end
      tests_run++;
      if (dc != last_wr_beat_cyc + 1) begin tests_failed++;
         $display("FAIL t1_done_timing: done cycle %0d last beat cycle %0d, required +1", dc, last_wr_beat_cyc); end
      tests_run++;
      if (mem[4] !== exp_mem[4] || mem[5] !== exp_mem[5] || mem[6] !== exp_mem[6]) begin tests_failed++;
         $display("FAIL t1_mem: got %h %h %h required %h %h %h", mem[4], mem[5], mem[6], exp_mem[4], exp_mem[5], exp_mem[6]); end
      tick();
      tests_run++;
      if (done_cnt - d0 != 1 || cmd_ready !== 1'b1) begin tests_failed++;
         $display("FAIL t1_done_once: done pulses %0d cmd_ready=%b required 1/1", done_cnt - d0, cmd_ready); end
   endtask

   task automatic test_multi_write();
      int s0 = wr_seq, b0 = wr_bursts, h0 = hs_cnt, d0 = done_cnt, acc, dc;
      issue_cmd(1'b1, 32'h0, 20, 1'b0, acc);
      wait_done(200, dc);
      tick();
      for (int i = 0; i < 20; i++) exp_mem[i] = data_fn(s0 + i);
      tests_run++;
      if (wr_bursts - b0 != 3) begin tests_failed++;
         $display("FAIL t2_burst_cnt: got %0d required 3", wr_bursts - b0); end
      tests_run++;
      if (wr_addr_log[b0] != 32'h00 || wr_addr_log[b0+1] != 32'h20 || wr_addr_log[b0+2] != 32'h40) begin tests_failed++;
         $display("FAIL t2_addrs: got %h %h %h required 00 20 40", wr_addr_log[b0], wr_addr_log[b0+1], wr_addr_log[b0+2]); end
      tests_run++;
      if (wr_bc_log[b0] != 8 || wr_bc_log[b0+1] != 8 || wr_bc_log[b0+2] != 4) begin tests_failed++;
         $display("FAIL t2_bcs: got %0d %0d %0d required 8 8 4", wr_bc_log[b0], wr_bc_log[b0+1], wr_bc_log[b0+2]); end
      tests_run++;
      if (hs_cnt - h0 != 20 || done_cnt - d0 != 1) begin tests_failed++;
         $display("FAIL t2_handshakes: hs=%0d done=%0d required 20/1", hs_cnt - h0, done_cnt - d0); end
   endtask

   task automatic test_multi_read();
      int b0 = rd_bursts, r0 = rd_cnt, acc, dc;
      rd_q.delete();
      issue_cmd(1'b0, 32'h0, 20, 1'b0, acc);
      wait_done(300, dc);
      tests_run++;
      if (rd_valid !== 1'b1 || rd_cnt - r0 != 19) begin tests_failed++;
         $display("FAIL t3_done_with_last: rd_valid=%b prior pulses=%0d required 1/19", rd_valid, rd_cnt - r0); end
      tick();
      tests_run++;
      if (rd_bursts - b0 != 3 || rd_bc_log[b0] != 8 || rd_bc_log[b0+1] != 8 || rd_bc_log[b0+2] != 4) begin tests_failed++;
         $display("FAIL t3_rd_cmds: n=%0d bc=%0d %0d %0d required 3: 8 8 4", rd_bursts - b0, rd_bc_log[b0], rd_bc_log[b0+1], rd_bc_log[b0+2]); end
      tests_run++;
      if (rd_addr_log[b0] != 32'h00 || rd_addr_log[b0+1] != 32'h20 || rd_addr_log[b0+2] != 32'h40) begin tests_failed++;
         $display("FAIL t3_rd_addrs: got %h %h %h required 00 20 40", rd_addr_log[b0], rd_addr_log[b0+1], rd_addr_log[b0+2]); end
      tests_run++;
      if (rd_cnt - r0 != 20) begin tests_failed++;
         $display("FAIL t3_rd_count: got %0d required 20", rd_cnt - r0); end
      for (int i = 0; i < 20; i++) begin
         logic [31:0] got;
         got = (i < rd_q.size()) ? rd_q[i] : 32'hxxxxxxxx;
         tests_run++;
         if (got !== exp_mem[i]) begin tests_failed++;
            $display("FAIL t3_data[%0d]: got %h required %h", i, got, exp_mem[i]); end
      end
   endtask

   task automatic test_stall_roundtrip();
      int s0, b0, h0, rb0, r0, acc, dc;
      stall_mode = 1'b1; gap_mode = 1'b1;
      s0 = wr_seq; b0 = wr_bursts; h0 = hs_cnt;
      issue_cmd(1'b1, 32'h100, 37, 1'b0, acc);
      wait_done(3000, dc);
      tick();
      for (int i = 0; i < 37; i++) exp_mem[64 + i] = data_fn(s0 + i);
      tests_run++;
      if (hs_cnt - h0 != 37 || wr_bursts - b0 != 5) begin tests_failed++;
         $display("FAIL t4_wr_counts: hs=%0d bursts=%0d required 37/5", hs_cnt - h0, wr_bursts - b0); end
      for (int k = 0; k < 5; k++) begin
         tests_run++;
         if (wr_addr_log[b0+k] != 32'h100 + 32 * k || wr_bc_log[b0+k] != ((k == 4) ? 5 : 8)) begin tests_failed++;
            $display("FAIL t4_wr_burst[%0d]: addr=%h bc=%0d required %h/%0d", k, wr_addr_log[b0+k], wr_bc_log[b0+k],
                     32'h100 + 32 * k, (k == 4) ? 5 : 8); end
      end
      rb0 = rd_bursts; r0 = rd_cnt;
      rd_q.delete();
      issue_cmd(1'b0, 32'h100, 37, 1'b0, acc);
      wait_done(3000, dc);
      tick();
      tests_run++;
      if (rd_cnt - r0 != 37 || rd_bursts - rb0 != 5) begin tests_failed++;
         $display("FAIL t4_rd_counts: pulses=%0d bursts=%0d required 37/5", rd_cnt - r0, rd_bursts - rb0); end
      for (int i = 0; i < 37; i++) begin
         logic [31:0] got;
         got = (i < rd_q.size()) ? rd_q[i] : 32'hxxxxxxxx;
         tests_run++;
         if (got !== exp_mem[64 + i]) begin tests_failed++;
            $display("FAIL t4_data[%0d]: got %h required %h", i, got, exp_mem[64 + i]); end
      end
      tests_run++;
      if (stab_err != 0 || ovl_err != 0) begin tests_failed++;
         $display("FAIL t4_burst_rules: unstable=%0d overlapping=%0d required 0/0", stab_err, ovl_err); end
      stall_mode = 1'b0; gap_mode = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_zero_len_and_busy();
      int a0 = act_cnt, d0, rb0, wb0, s0, acc, dc;
      issue_cmd(1'b1, 32'h40, 0, 1'b0, acc);
      tests_run++;
      if (done !== 1'b1 || cyc != acc + 1) begin tests_failed++;
         $display("FAIL t5_zero_done: done=%b cycle=%0d required 1 at %0d", done, cyc, acc + 1); end
      tick();
      tests_run++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || act_cnt != a0) begin tests_failed++;
         $display("FAIL t5_zero_quiet: done=%b cmd_ready=%b avm activity=%0d required 0/1/0", done, cmd_ready, act_cnt - a0); end
      d0 = done_cnt; rb0 = rd_bursts; wb0 = wr_bursts; s0 = wr_seq;
      issue_cmd(1'b1, 32'h200, 4, 1'b1, acc);
      // Keep presenting a read command while the write runs; it must be ignored.
      cmd_write = 1'b0; cmd_addr = 32'h80; cmd_len = 16'd5;
      wait_done(200, dc);
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) exp_mem[128 + i] = data_fn(s0 + i);
      tests_run++;
      if (rd_bursts != rb0 || wr_bursts - wb0 != 1 || done_cnt - d0 != 1 || busy !== 1'b0) begin tests_failed++;
         $display("FAIL t5_busy_ignore: rd=%0d wr=%0d done=%0d busy=%b required 0/1/1/0", rd_bursts - rb0, wr_bursts - wb0, done_cnt - d0, busy); end
      tests_run++;
      if (mem[128] !== exp_mem[128] || mem[131] !== exp_mem[131]) begin tests_failed++;
         $display("FAIL t5_mem: got %h %h required %h %h", mem[128], mem[131], exp_mem[128], exp_mem[131]); end
   endtask

   task automatic test_reset_mid_read();
      int r0 = rd_cnt, r1, n = 0, acc, dc;
      issue_cmd(1'b0, 32'h0, 8, 1'b0, acc);
      while (rd_cnt - r0 < 2 && n < 100) begin tick(); n++; end
      tests_run++;
      if (rd_cnt - r0 < 2) begin tests_failed++;
         $display("FAIL t6_reach_beat2: pulses=%0d required 2", rd_cnt - r0); end
      reset = 1'b1;
      tick();
      tests_run++;
      if ({cmd_ready, busy, done, avm_read, avm_write, wr_ready, rd_valid, avm_byteenable,
           avm_burstcount, avm_address, rd_data, avm_writedata} !== '0) begin tests_failed++;
         $display("FAIL t6_reset_outputs: busy=%b rd_valid=%b be=%h addr=%h bc=%0d required all 0",
                  busy, rd_valid, avm_byteenable, avm_address, avm_burstcount); end
      reset = 1'b0;
      tick();
      r1 = rd_cnt;
      repeat (10) tick();
      tests_run++;
      if (rd_cnt != r1 || cmd_ready !== 1'b1) begin tests_failed++;
         $display("FAIL t6_after_reset: stray pulses=%0d cmd_ready=%b required 0/1", rd_cnt - r1, cmd_ready); end
      rd_q.delete();
      r0 = rd_cnt;
      issue_cmd(1'b0, 32'h10, 3, 1'b0, acc);
      wait_done(100, dc);
      tick();
      tests_run++;
      if (rd_cnt - r0 != 3 || rd_q.size() != 3) begin tests_failed++;
         $display("FAIL t6_new_cmd_count: got %0d required 3", rd_cnt - r0); end
      else begin
         for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (rd_q[i] !== exp_mem[4 + i]) begin tests_failed++;
               $display("FAIL t6_data[%0d]: got %h required %h", i, rd_q[i], exp_mem[4 + i]); end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_write();
      test_multi_write();
      test_multi_read();
      test_stall_roundtrip();
      test_zero_len_and_busy();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
